// File: rtl/axil_regfile_if.sv
// AXI4-Lite channel bundle between the WB bridge master and the register bank.
interface axil_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axil_regfile.sv
// AXI4-Lite word-indexed RW/RO register bank.
// Define AXIL_REGFILE_SLVERR_EN to return SLVERR on illegal accesses.
module axil_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_STATUS = 4
) (
  input  logic                             CLK,
  input  logic                             RSTN,
  axil_regfile_if.slave                    AXI,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   REGS_OUT,
  output logic [NUM_REGS-1:0]              WR_PULSE,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] STATUS_IN
);

  localparam int NB = DATA_WIDTH / 8;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  logic                  aw_held;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;

  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  rvalid;
  logic [1:0]            rresp;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_ok;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_ok;

  logic unused;
  assign unused = ^{AXI.AWPROT, AXI.ARPROT};

  assign AXI.AWREADY = !aw_held && !bvalid;
  assign AXI.WREADY  = !w_held && !bvalid;
  assign AXI.ARREADY = !rvalid;
  assign AXI.BVALID  = bvalid;
  assign AXI.BRESP   = bresp;
  assign AXI.RVALID  = rvalid;
  assign AXI.RRESP   = rresp;
  assign AXI.RDATA   = rdata;

  assign aw_hs  = AXI.AWVALID && AXI.AWREADY;
  assign w_hs   = AXI.WVALID && AXI.WREADY;
  assign ar_hs  = AXI.ARVALID && AXI.ARREADY;
  assign commit = aw_held && w_held && !bvalid;

  assign REGS_OUT = regs;

  // Full-width compares so high index bits never alias onto a register.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (aw_idx == ADDR_WIDTH'(i));
    end
    wr_ok = |wr_sel;
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (AXI.ARADDR == ADDR_WIDTH'(i)) begin
        rd_val = regs[i];
        rd_ok  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (AXI.ARADDR == ADDR_WIDTH'(NUM_REGS + j)) begin
        rd_val = STATUS_IN[j*DATA_WIDTH +: DATA_WIDTH];
        rd_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= AXI.AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= AXI.WDATA;
        w_strb <= AXI.WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      regs     <= '0;
      WR_PULSE <= '0;
    end else begin
      WR_PULSE <= '0;
      if (commit) begin
        WR_PULSE <= wr_sel;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_sel[i] && w_strb[b]) begin
              regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= wr_ok ? 2'b00 : ERR_RESP;
    end else if (bvalid && AXI.BREADY) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rvalid <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= rd_ok ? 2'b00 : ERR_RESP;
      rdata  <= rd_val;
    end else if (rvalid && AXI.RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile.
// Honours AXIL_REGFILE_SLVERR_EN for expected error responses.
module tb_axil_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NS = 4;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic              clk;
  logic              rst_n;
  logic [NR*DW-1:0]  regs_out;
  logic [NR-1:0]     wr_pulse;
  logic [NS*DW-1:0]  status_in;
  logic [NR*DW-1:0]  exp_regs;

  int checks = 0;
  int passes = 0;

  axil_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .NUM_STATUS(NS)
  ) dut (
    .CLK      (clk),
    .RSTN     (rst_n),
    .AXI      (bus.slave),
    .REGS_OUT (regs_out),
    .WR_PULSE (wr_pulse),
    .STATUS_IN(status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_write(input string tag,
                          input logic [AW-1:0] idx,
                          input logic [DW-1:0] data,
                          input logic [3:0] strb,
                          input logic [1:0] exp_resp,
                          input logic [NR-1:0] exp_pulse);
    @(negedge clk);
    bus.AWADDR  = idx;
    bus.AWVALID = 1'b1;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.WVALID  = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk({tag, "_bv_early"}, bus.BVALID, 1'b0);
    @(negedge clk);
    chk({tag, "_bvalid"}, bus.BVALID, 1'b1);
    chk({tag, "_bresp"}, bus.BRESP, exp_resp);
    chk({tag, "_pulse"}, wr_pulse, exp_pulse);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk({tag, "_bv_clr"}, bus.BVALID, 1'b0);
    chk({tag, "_pulse_clr"}, wr_pulse, '0);
  endtask

  task automatic do_read(input string tag,
                         input logic [AW-1:0] idx,
                         input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp);
    @(negedge clk);
    bus.ARADDR  = idx;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    chk({tag, "_rvalid"}, bus.RVALID, 1'b1);
    chk({tag, "_rdata"}, bus.RDATA, exp_data);
    chk({tag, "_rresp"}, bus.RRESP, exp_resp);
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    chk({tag, "_rv_clr"}, bus.RVALID, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.AWADDR  = '0;
    bus.AWPROT  = 3'b000;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = '0;
    bus.ARPROT  = 3'b000;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    status_in   = '0;
    exp_regs    = '0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_regs", regs_out, '0);
    chk("rst_pulse", wr_pulse, '0);
    chk("rst_rdata", bus.RDATA, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", bus.AWREADY, 1'b1);
    chk("idle_wready", bus.WREADY, 1'b1);
    chk("idle_arready", bus.ARREADY, 1'b1);

    do_read("rd3_rst", 32'd3, 32'h0000_0000, 2'b00);

    do_write("wr2_full", 32'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 16'h0004);
    exp_regs[2*DW +: DW] = 32'hDEAD_BEEF;
    chk("regs_after_wr2", regs_out, exp_regs);
    do_read("rd2_full", 32'd2, 32'hDEAD_BEEF, 2'b00);

    // W ahead of AW, partial strobe, then slow BREADY
    @(negedge clk);
    bus.WDATA  = 32'h0000_00AA;
    bus.WSTRB  = 4'h1;
    bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    chk("wfirst_wready", bus.WREADY, 1'b0);
    chk("wfirst_awready", bus.AWREADY, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wfirst_no_bv", bus.BVALID, 1'b0);
    bus.AWADDR  = 32'd2;
    bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    @(negedge clk);
    chk("wfirst_pulse", wr_pulse, 16'h0004);
    for (int c = 0; c < 5; c++) begin
      chk("hold_bvalid", bus.BVALID, 1'b1);
      chk("hold_bresp", bus.BRESP, 2'b00);
      chk("hold_awready", bus.AWREADY, 1'b0);
      chk("hold_wready", bus.WREADY, 1'b0);
      @(negedge clk);
    end
    chk("hold_pulse_gone", wr_pulse, '0);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk("hold_bv_clr", bus.BVALID, 1'b0);
    exp_regs[2*DW +: DW] = 32'hDEAD_BEAA;
    chk("regs_partial", regs_out, exp_regs);

    status_in[0*DW +: DW] = 32'h1234_5678;
    status_in[3*DW +: DW] = 32'hCAFE_F00D;
    do_read("rd16_status", 32'd16, 32'h1234_5678, 2'b00);
    do_read("rd19_status", 32'd19, 32'hCAFE_F00D, 2'b00);
    do_write("wr16_ro", 32'd16, 32'hFFFF_FFFF, 4'hF, ERR, 16'h0000);
    chk("regs_after_ro", regs_out, exp_regs);
    do_read("rd16_again", 32'd16, 32'h1234_5678, 2'b00);

    do_write("wr_alias", 32'h1000_0002, 32'h5555_5555, 4'hF, ERR, 16'h0000);
    chk("regs_after_alias", regs_out, exp_regs);
    do_write("wr15_last", 32'd15, 32'h0BAD_0F0F, 4'hC, 2'b00, 16'h8000);
    exp_regs[15*DW +: DW] = 32'h0BAD_0000;
    chk("regs_after_wr15", regs_out, exp_regs);
    do_read("rd20_oor", 32'd20, 32'h0, ERR);

    // out-of-range read with RREADY held low
    @(negedge clk);
    bus.ARADDR  = 32'd100;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rhold_rvalid", bus.RVALID, 1'b1);
      chk("rhold_arready", bus.ARREADY, 1'b0);
      chk("rhold_rdata", bus.RDATA, 32'h0);
      chk("rhold_rresp", bus.RRESP, ERR);
      @(negedge clk);
    end
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    chk("rhold_clr", bus.RVALID, 1'b0);

    // reset while AW is parked and a read response is pending
    @(negedge clk);
    bus.AWADDR  = 32'd2;
    bus.AWVALID = 1'b1;
    bus.ARADDR  = 32'd2;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    bus.ARVALID = 1'b0;
    chk("mid_awready", bus.AWREADY, 1'b0);
    chk("mid_rvalid", bus.RVALID, 1'b1);
    chk("mid_rdata", bus.RDATA, 32'hDEAD_BEAA);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.RVALID, 1'b0);
    chk("mid_rst_rdata", bus.RDATA, '0);
    chk("mid_rst_regs", regs_out, '0);
    chk("mid_rst_awready", bus.AWREADY, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_no_bv", bus.BVALID, 1'b0);
    do_read("rd2_post_rst", 32'd2, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- AXI4-Lite slave register bank that sits directly downstream of the Wishbone-to-AXI4-Lite bridge and terminates its master port.
- Provides NUM_REGS read/write control registers and NUM_STATUS read-only status words to the rest of the design.
- Addresses arrive already word-indexed: the bridge subtracts its base and shifts right by 2. AWADDR/ARADDR are register indices, not byte addresses.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR (word index)
DATA_WIDTH, 32, data width; multiple of 8
NUM_REGS, 16, count of RW registers, indices 0..NUM_REGS-1
NUM_STATUS, 4, count of RO status words, indices NUM_REGS..NUM_REGS+NUM_STATUS-1

Ports:
CLK  in  1  clock
RSTN  in  1  reset, asynchronous, active-low
AXI_AWADDR  in  ADDR_WIDTH  write word index
AXI_AWPROT  in  3  ignored
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address ready
AXI_WDATA  in  DATA_WIDTH  write data
AXI_WSTRB  in  DATA_WIDTH/8  byte enables
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data ready
AXI_BRESP  out  2  write response
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_ARADDR  in  ADDR_WIDTH  read word index
AXI_ARPROT  in  3  ignored
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address ready
AXI_RDATA  out  DATA_WIDTH  read data
AXI_RRESP  out  2  read response
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  read data ready
REGS_OUT  out  NUM_REGS*DATA_WIDTH  flattened RW registers; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
WR_PULSE  out  NUM_REGS  one-cycle strobe per RW register on a committed write
STATUS_IN  in  NUM_STATUS*DATA_WIDTH  flattened status words, same packing

Behaviour:
- Reset (RSTN low, async): all registers 0; aw_held/w_held/BVALID/RVALID = 0; BRESP/RRESP/RDATA = 0; WR_PULSE = 0. After reset AWREADY = WREADY = ARREADY = 1. Reset mid-transaction drops all in-flight state; no response is issued.
- Write capture:
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW and W are captured independently into holding registers on their own handshakes, in either order or in the same cycle.
- Write commit: on the first edge where aw_held && w_held && !BVALID:
  - If the index is < NUM_REGS, write each byte b where WSTRB[b]=1; bytes with WSTRB[b]=0 are unchanged.
  - WR_PULSE[idx] = 1 for exactly that cycle; it is 0 for a non-RW index.
  - BVALID <= 1; both holds clear.
  - Latency: AW+W handshake at edge N, register update and BVALID visible after edge N+1.
- Write response: BVALID and BRESP stay stable until BREADY. BVALID clears on the BVALID && BREADY edge; AW/W can be accepted again from the next cycle.
- Writes to an RO or out-of-range index: no register change, no pulse. BRESP per the Optional Feature.
- Read:
  - ARREADY = !RVALID.
  - On the AR handshake edge: RDATA <= register or STATUS_IN word at that index (0 if out of range); RVALID <= 1.
  - RDATA/RRESP are held stable until RVALID && RREADY. RVALID clears on that edge.
  - STATUS_IN is sampled at the AR edge without a synchroniser; the source must be CLK-synchronous.
- Simultaneous events:
  - A read of index k on the same edge as a write commit to k returns the old value.
  - Read and write channels are fully independent; no ordering between them is guaranteed.
- Range rule: index compare uses the full ADDR_WIDTH bits with no aliasing.

Optional Feature:
- Macro: AXIL_REGFILE_SLVERR_EN.
- Defined: writes to RO/out-of-range indices return BRESP=2'b10 (SLVERR). Reads beyond NUM_REGS+NUM_STATUS-1 return RRESP=2'b10, RDATA=0.
- Undefined: all responses are OKAY (2'b00); illegal writes are silently dropped and illegal reads return 0.
- The upstream bridge maps RESP[1] to WB_ERR.

Test Plan:
- After reset, read idx 3 -> RDATA=0x00000000, RRESP=0; AWREADY=WREADY=ARREADY=1.
- AW idx 2 and W 0xDEADBEEF, WSTRB=0xF in the same cycle -> BVALID one cycle later, BRESP=0, WR_PULSE[2] single pulse. Read idx 2 -> 0xDEADBEEF.
- W before AW: W 0x000000AA, WSTRB=0x1 at cycle 0, AW idx 2 at cycle 3 -> reg2=0xDEADBEAA. Hold BREADY low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout.
- STATUS_IN word0=0x12345678, read idx NUM_REGS(16) -> 0x12345678. Write idx 16 -> value unchanged, no WR_PULSE. BRESP=0 without macro, 2'b10 with it.
- Read idx 100 -> RDATA=0, RRESP=0 without macro, 2'b10 with it. Hold RREADY low 3 cycles -> ARREADY=0 and RDATA stable.
- Pulse RSTN low while aw_held=1 and RVALID=1 -> outputs zero immediately, no BVALID; reg2 reads 0 afterwards.
